nes_button_conditioner: RTL



---
 rtl/nes_button_conditioner_pkg.sv | 26 ++
 rtl/nes_button_conditioner_channel.sv | 126 ++++++++++++
 rtl/nes_button_conditioner.sv | 75 +++++++
 3 files changed

// File: rtl/nes_button_conditioner_pkg.sv
// Shared types and parameter helpers for the NES button conditioner.
// Repeat FSM encodings are fixed: IDLE=2'd0, DELAY=2'd1, REPEAT=2'd2.
package nes_button_conditioner_pkg;

  localparam int unsigned NUM_BUTTONS = 8;

  typedef enum logic [1:0] {
    RPT_IDLE   = 2'd0,
    RPT_DELAY  = 2'd1,
    RPT_REPEAT = 2'd2
  } rpt_state_e;

  // Per-channel result bundle, one bit per output port.
  typedef struct packed {
    logic held;
    logic pressed;
    logic released;
    logic rpt;
  } chan_evt_t;

  // True when val fits a counter of the given width and is at least 1.
  function automatic logic param_ok(input int unsigned val, input int unsigned width);
    return (val >= 1) && (64'(val) < (64'(1) << width));
  endfunction

endpackage

// File: rtl/nes_button_conditioner_channel.sv
// Single-button conditioner: sample-counted debounce followed by an
// auto-repeat FSM that paces pulses in samples rather than clocks.
module nes_button_channel
  import nes_button_conditioner_pkg::*;
#(
  parameter int unsigned STABLE_SAMPLES = 2,
  parameter int unsigned REPEAT_DELAY   = 30,
  parameter int unsigned REPEAT_RATE    = 6,
  parameter int unsigned CNT_WIDTH      = 6
) (
  input  logic      i_clk,
  input  logic      i_rst_n,
  input  logic      i_valid,
  input  logic      i_raw,
  output chan_evt_t o_evt
);

  localparam logic [CNT_WIDTH-1:0] STABLE_TH = CNT_WIDTH'(STABLE_SAMPLES);
  localparam logic [CNT_WIDTH-1:0] DELAY_TH  = CNT_WIDTH'(REPEAT_DELAY);
  localparam logic [CNT_WIDTH-1:0] RATE_TH   = CNT_WIDTH'(REPEAT_RATE);

  logic                 held_q, held_d;
  logic                 pressed_q, pressed_d;
  logic                 released_q, released_d;
  logic                 rpt_q, rpt_d;
  logic [CNT_WIDTH-1:0] deb_cnt_q, deb_cnt_d;
  logic [CNT_WIDTH-1:0] rpt_cnt_q, rpt_cnt_d;
  rpt_state_e           state_q, state_d;

  logic [CNT_WIDTH-1:0] deb_nxt;
  logic [CNT_WIDTH-1:0] rpt_nxt;

  assign deb_nxt = deb_cnt_q + CNT_WIDTH'(1);
  assign rpt_nxt = rpt_cnt_q + CNT_WIDTH'(1);

  // Debounce and repeat update, evaluated only on a fresh sample.
  always_comb begin
    held_d     = held_q;
    deb_cnt_d  = deb_cnt_q;
    rpt_cnt_d  = rpt_cnt_q;
    state_d    = state_q;
    pressed_d  = 1'b0;
    released_d = 1'b0;
    rpt_d      = 1'b0;

    if (i_valid) begin
      if (i_raw == held_q) begin
        deb_cnt_d = '0;
      end else if (deb_nxt == STABLE_TH) begin
        held_d     = ~held_q;
        deb_cnt_d  = '0;
        pressed_d  = ~held_q;
        released_d = held_q;
      end else begin
        deb_cnt_d = deb_nxt;
      end

      // A release always wins and silences the repeat path.
      if (released_d) begin
        state_d   = RPT_IDLE;
        rpt_cnt_d = '0;
      end else begin
        unique case (state_q)
          RPT_IDLE: begin
            if (pressed_d) begin
              rpt_d     = 1'b1;
              rpt_cnt_d = '0;
              state_d   = RPT_DELAY;
            end
          end
          RPT_DELAY: begin
            if (held_q) begin
              if (rpt_nxt == DELAY_TH) begin
                rpt_d     = 1'b1;
                rpt_cnt_d = '0;
                state_d   = RPT_REPEAT;
              end else begin
                rpt_cnt_d = rpt_nxt;
              end
            end
          end
          RPT_REPEAT: begin
            if (held_q) begin
              if (rpt_nxt == RATE_TH) begin
                rpt_d     = 1'b1;
                rpt_cnt_d = '0;
              end else begin
                rpt_cnt_d = rpt_nxt;
              end
            end
          end
          default: begin
            state_d   = RPT_IDLE;
            rpt_cnt_d = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      held_q     <= 1'b0;
      pressed_q  <= 1'b0;
      released_q <= 1'b0;
      rpt_q      <= 1'b0;
      deb_cnt_q  <= '0;
      rpt_cnt_q  <= '0;
      state_q    <= RPT_IDLE;
    end else begin
      held_q     <= held_d;
      pressed_q  <= pressed_d;
      released_q <= released_d;
      rpt_q      <= rpt_d;
      deb_cnt_q  <= deb_cnt_d;
      rpt_cnt_q  <= rpt_cnt_d;
      state_q    <= state_d;
    end
  end

  assign o_evt.held     = held_q;
  assign o_evt.pressed  = pressed_q;
  assign o_evt.released = released_q;
  assign o_evt.rpt      = rpt_q;

endmodule

// File: rtl/nes_button_conditioner.sv
// Debounces validated NES controller samples and derives held levels,
// press/release edges and frame-paced auto-repeat pulses for all 8 buttons.
module nes_button_conditioner
  import nes_button_conditioner_pkg::*;
#(
  parameter int unsigned STABLE_SAMPLES = 2,
  parameter int unsigned REPEAT_DELAY   = 30,
  parameter int unsigned REPEAT_RATE    = 6,
  parameter int unsigned CNT_WIDTH      = 6
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_valid,
  input  logic [NUM_BUTTONS-1:0] i_buttons,
  output logic [NUM_BUTTONS-1:0] o_held,
  output logic [NUM_BUTTONS-1:0] o_pressed,
  output logic [NUM_BUTTONS-1:0] o_released,
  output logic [NUM_BUTTONS-1:0] o_repeat,
  output logic                   o_strobe
);

  // Reject parameter sets whose thresholds cannot be reached by the counters.
  if (CNT_WIDTH < 1 || CNT_WIDTH > 31) begin : g_bad_width
    $error("nes_button_conditioner: CNT_WIDTH must be 1..31");
  end
  if (!param_ok(STABLE_SAMPLES, CNT_WIDTH)) begin : g_bad_stable
    $error("nes_button_conditioner: STABLE_SAMPLES out of range");
  end
  if (!param_ok(REPEAT_DELAY, CNT_WIDTH)) begin : g_bad_delay
    $error("nes_button_conditioner: REPEAT_DELAY out of range");
  end
  if (!param_ok(REPEAT_RATE, CNT_WIDTH)) begin : g_bad_rate
    $error("nes_button_conditioner: REPEAT_RATE out of range");
  end

  chan_evt_t evt [NUM_BUTTONS];

  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_chan
    nes_button_channel #(
      .STABLE_SAMPLES(STABLE_SAMPLES),
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_RATE   (REPEAT_RATE),
      .CNT_WIDTH     (CNT_WIDTH)
    ) u_chan (
      .i_clk  (i_clk),
      .i_rst_n(i_rst_n),
      .i_valid(i_valid),
      .i_raw  (i_buttons[i]),
      .o_evt  (evt[i])
    );

    assign o_held[i]     = evt[i].held;
    assign o_pressed[i]  = evt[i].pressed;
    assign o_released[i] = evt[i].released;
    assign o_repeat[i]   = evt[i].rpt;
  end

  logic strobe_q, strobe_d;

  // Strobe marks every processed sample, changed or not.
  always_comb begin
    strobe_d = i_valid;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      strobe_q <= 1'b0;
    end else begin
      strobe_q <= strobe_d;
    end
  end

  assign o_strobe = strobe_q;

endmodule
